// File: rtl/egress_fsm_pkg.sv
// Shared egress/ingress types: AXIS source/sink structs, frame status flags and header word counts.
// The PAD state only exists when EGRESS_PAD_EN is defined.
package egress_fsm_pkg;

  localparam logic [15:0] SFD_WORD   = 16'hAAAB;
  localparam int          MAC_WORDS  = 3;
  localparam int          TYPE_WORDS = 1;
  localparam int          HDR_WORDS  = 2 * MAC_WORDS + TYPE_WORDS;

  typedef struct packed {
    logic        tvalid;
    logic [15:0] tdata;
    logic        tlast;
  } axis_source_t;

  typedef struct packed {
    logic tready;
  } axis_sink_t;

  typedef struct packed {
    logic scan_frame;
    logic scan_dst_mac;
    logic scan_src_mac;
    logic scan_type;
    logic scan_payload;
  } frame_status;

  localparam frame_status PAYLOAD_STATUS =
    '{scan_frame: 1'b1, scan_payload: 1'b1, default: 1'b0};

`ifdef EGRESS_PAD_EN
  typedef enum logic [2:0] {ST_IDLE, ST_SFD, ST_HDR, ST_PAYLOAD, ST_GAP, ST_PAD} state_e;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_SFD, ST_HDR, ST_PAYLOAD, ST_GAP} state_e;
`endif

  // Header word index -> which field is on the wire.
  function automatic frame_status hdr_status(input logic [2:0] cnt);
    frame_status fs;
    fs            = '0;
    fs.scan_frame = 1'b1;
    if (int'(cnt) < MAC_WORDS)          fs.scan_dst_mac = 1'b1;
    else if (int'(cnt) < 2 * MAC_WORDS) fs.scan_src_mac = 1'b1;
    else                                fs.scan_type    = 1'b1;
    return fs;
  endfunction

endpackage

// File: rtl/egress_fsm_if.sv
// Egress AXIS port: source carries tvalid/tdata/tlast, sink carries tready.
interface egress_fsm_if;
  import egress_fsm_pkg::*;

  axis_source_t source;
  axis_sink_t   sink;

  modport master (output source, input sink);
  modport slave  (input source, output sink);
endinterface

// File: rtl/egress_fsm_pending_frame_counter.sv
// Saturating up/down count of frames committed to the FIFO but not yet fully drained.
module pending_frame_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d  = count_q;
    overflow = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (count_q == MAX) overflow = 1'b1;
        else                count_d  = count_q + W'(1);
      end
      2'b01: begin
        if (count_q != '0) count_d = count_q - W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/egress_fsm.sv
// Egress sequencer: SFD, header, payload and inter-frame gap from the packet FIFO onto AXIS.
// Define EGRESS_PAD_EN to zero-pad short frames up to MIN_FRAME_WORDS words.
module egress_fsm
  import egress_fsm_pkg::*;
#(
  parameter int FRAME_CNT_W     = 4,
  parameter int IFG_CYCLES      = 6
`ifdef EGRESS_PAD_EN
  , parameter int MIN_FRAME_WORDS = 30
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [16:0]        fifo_rdata,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic               frame_commit,
  egress_fsm_if.master       egress,
  output frame_status        status,
  output logic               underrun,
  output logic               overflow
);

  localparam int               GAP_W     = $clog2(IFG_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_START = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(IFG_CYCLES - 1);
  localparam logic [2:0]       HDR_LAST  = 3'(HDR_WORDS - 1);
`ifdef EGRESS_PAD_EN
  localparam logic [5:0]       MIN_LAST  = 6'(MIN_FRAME_WORDS - 1);
  localparam logic [5:0]       WORD_MAX  = 6'h3F;
`endif

  state_e             state_q, state_d;
  logic [2:0]         hdr_cnt_q, hdr_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
`ifdef EGRESS_PAD_EN
  logic [5:0]         word_cnt_q, word_cnt_d;
  logic               short_frame;
`endif
  logic [FRAME_CNT_W-1:0] pending;
  logic               fifo_tlast;
  logic               handshake;
  axis_source_t       source_s;

  assign fifo_tlast    = fifo_rdata[16];
  assign egress.source = source_s;

  pending_frame_counter #(.W(FRAME_CNT_W)) u_pending (
    .clk      (clk),
    .reset    (reset),
    .inc      (frame_commit),
    .dec      (fifo_rd_en & fifo_tlast),
    .count    (pending),
    .overflow (overflow)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    gap_cnt_d  = gap_cnt_q;
`ifdef EGRESS_PAD_EN
    word_cnt_d  = word_cnt_q;
    short_frame = 1'b0;
`endif
    source_s   = '0;
    status     = '0;
    fifo_rd_en = 1'b0;
    underrun   = 1'b0;
    handshake  = 1'b0;

    case (state_q)
      ST_IDLE: if (pending != '0) state_d = ST_SFD;

      ST_SFD: begin
        source_s.tvalid = 1'b1;
        source_s.tdata  = SFD_WORD;
        if (egress.sink.tready) begin
          state_d   = ST_HDR;
          hdr_cnt_d = '0;
`ifdef EGRESS_PAD_EN
          word_cnt_d = '0;
`endif
        end
      end

      ST_HDR, ST_PAYLOAD: begin
        source_s.tvalid = ~fifo_empty;
        source_s.tdata  = fifo_rdata[15:0];
        source_s.tlast  = fifo_tlast;
        underrun        = fifo_empty;
        status          = (state_q == ST_HDR) ? hdr_status(hdr_cnt_q) : PAYLOAD_STATUS;
`ifdef EGRESS_PAD_EN
        // A tlast arriving before the minimum length is hidden; PAD supplies the real one.
        short_frame    = fifo_tlast && (word_cnt_q < MIN_LAST);
        source_s.tlast = fifo_tlast && !short_frame;
`endif
        handshake  = source_s.tvalid & egress.sink.tready;
        fifo_rd_en = handshake;
        if (handshake) begin
`ifdef EGRESS_PAD_EN
          if (word_cnt_q != WORD_MAX) word_cnt_d = word_cnt_q + 6'd1;
`endif
          if (fifo_tlast) begin
`ifdef EGRESS_PAD_EN
            if (short_frame) begin
              state_d = ST_PAD;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_START;
            end
`else
            state_d   = ST_GAP;
            gap_cnt_d = GAP_START;
`endif
          end else if (state_q == ST_HDR) begin
            if (hdr_cnt_q == HDR_LAST) state_d   = ST_PAYLOAD;
            else                       hdr_cnt_d = hdr_cnt_q + 3'd1;
          end
        end
      end

`ifdef EGRESS_PAD_EN
      ST_PAD: begin
        source_s.tvalid = 1'b1;
        source_s.tlast  = (word_cnt_q == MIN_LAST);
        status          = PAYLOAD_STATUS;
        if (egress.sink.tready) begin
          if (word_cnt_q != WORD_MAX) word_cnt_d = word_cnt_q + 6'd1;
          if (source_s.tlast) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_START;
          end
        end
      end
`endif

      // The tlast cycle and the following IDLE cycle both count toward the gap,
      // so the next SFD lands exactly IFG_CYCLES+1 cycles after tlast.
      ST_GAP: begin
        if (gap_cnt_q >= GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hdr_cnt_q <= '0;
      gap_cnt_q <= '0;
`ifdef EGRESS_PAD_EN
      word_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      gap_cnt_q <= gap_cnt_d;
`ifdef EGRESS_PAD_EN
      word_cnt_q <= word_cnt_d;
`endif
    end
  end

endmodule
